ws2812_cfg_decoder: RTL and testbench
=====================================

# ws2812_cfg_decoder

Multi-channel, parameterised configuration decoder for the WS2812 LED driver. It pulls a byte stream from the write FIFO and parses it into framed configuration commands. Each frame updates one register (length, shift, delay or LED count) of one of `NUM_CH` driver channels. After every accepted frame it recomputes that channel's data depth and pulses a per-channel write strobe. It sits between the host-side write FIFO and the bank of WS2812 channel engines.

## Interface
Parameters:
- `NUM_CH`, 4: number of driver channels (1..16).
- `VAL_BYTES`, 2: bytes per value field, sent MSB first (1..4). `VAL_W = 8*VAL_BYTES` is derived.
- `TIMEOUT_CYCLES`, 1024: stall limit mid-frame. Used only with `WS2812_CFG_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `f_empty`  in  1  FIFO empty flag.
- `fifo_read_data`  in  8  FIFO read data; valid the cycle after `fifo_read_en`.
- `fifo_read_en`  out  1  one-cycle read strobe.
- `data_length`  out  NUM_CH*VAL_W  per-channel length; channel c at bits [c*VAL_W +: VAL_W].
- `data_shift`  out  NUM_CH*VAL_W  per-channel shift mode.
- `data_delay`  out  NUM_CH*VAL_W  per-channel delay.
- `num_leds`  out  NUM_CH*VAL_W  per-channel LED count.
- `data_depth`  out  NUM_CH*VAL_W  per-channel derived depth.
- `write`  out  NUM_CH  one-cycle per-channel update strobe.
- `cfg_err`  out  1  one-cycle error pulse.
- `busy`  out  1  high while a frame is partially received.

## Operation
- Frame format: opcode byte, then channel byte, then `VAL_BYTES` value bytes (MSB first).
- Opcode map:
  - 0x01: length
  - 0x02: shift
  - 0x03: delay
  - 0x04: num_leds
- Invalid opcode:
  - Pulse `cfg_err`, drop that byte only.
  - The next byte is parsed as an opcode (resync).
- Channel byte ≥ `NUM_CH`:
  - Still consume all value bytes.
  - Discard the frame, pulse `cfg_err` on the last byte's capture cycle, no `write`.
- State machine: `REQ` → `WAIT` → `CAPTURE` → (`REQ` | `COMMIT`), then `COMMIT` → `DEPTH` → `REQ`.
  - `REQ`: assert `fifo_read_en` for one cycle when `!f_empty`; otherwise stay in `REQ`.
  - `WAIT`: deassert `fifo_read_en`.
  - `CAPTURE`: store the byte into the field selected by the byte counter. The counter runs opcode=0, channel=1, value=2..VAL_BYTES+1.
  - `COMMIT`: load the assembled value into the addressed register.
  - `DEPTH`: recompute `data_depth[ch]` and pulse `write[ch]`.
- Depth recompute occurs only after a shift or num_leds commit. Length and delay commits leave depth unchanged but still pulse `write`.
  - shift = 0: depth = num_leds.
  - shift = 1: depth = num_leds − 1, saturating at 0.
  - shift = 2: depth = num_leds + 1, saturating at 2^VAL_W − 1.
  - Any other shift value: depth = num_leds.
- Recompute always uses the already-updated register values.
- At most one outstanding FIFO read. `fifo_read_en` is never asserted while `f_empty` is high.
- `busy` is high from opcode capture until `DEPTH`, or until the frame is dropped.

## Timing
- Reset:
  - All registers, `data_depth`, `write`, `cfg_err`, `fifo_read_en` and `busy` go to 0.
  - State goes to `REQ` and the byte counter to 0.
  - Reset mid-frame discards the partial frame.
- Each byte takes 3 cycles with a non-empty FIFO: `REQ`, `WAIT`, `CAPTURE`.
- One frame takes 3*(2+VAL_BYTES) + 2 cycles; 14 cycles at default parameters.
- The register output changes the cycle after the last `CAPTURE`.
- `data_depth` and `write[ch]` change on the following cycle. All outputs are final while `write[ch]` is high.
- `f_empty` is sampled only in `REQ`. A FIFO that empties mid-frame stalls the parser with no data loss.
- `write` and `cfg_err` are never high in the same cycle.

## Configuration
- Macro: `WS2812_CFG_TIMEOUT_EN`.
- Defined:
  - A stall counter runs while `busy` and in `REQ` with `f_empty` high.
  - When it reaches `TIMEOUT_CYCLES`, the partial frame is dropped with no register change.
  - `cfg_err` pulses and the counter returns to opcode.
  - The stall counter clears on any read.
- Undefined:
  - No counter is built and the parser waits indefinitely.

## Test plan
- Reset, then frame 04 00 00 0A → `num_leds[ch0]`=0x000A, `data_depth[ch0]`=0x000A, `write`=4'b0001 for one cycle, 14 cycles after first read.
- Frames 04 02 00 05, then 02 02 00 01 → ch2 depth 5 after the first frame, 4 after the second. A following 02 02 00 02 gives 6.
- num_leds=0 with shift=1 → depth=0 (saturates, no wrap). num_leds=0xFFFF with shift=2 → depth=0xFFFF.
- Byte 0x07, then 03 01 12 34 → one `cfg_err` pulse, then `data_delay[ch1]`=0x1234, `write[1]` pulses.
- Frame 01 05 00 10 with `NUM_CH`=4 → `cfg_err` pulse, no `write`, all registers unchanged. The next valid frame parses normally.
- Frame 01 00 00 with FIFO empty for 2000 cycles:
  - With the macro, `cfg_err` at stall cycle 1024, `data_length` unchanged, next frame parses.
  - Without the macro, `busy` stays high, then a late 0x20 completes with length 0x0020.

Source files
------------

// File: rtl/ws2812_cfg_decoder.sv
// Byte-stream configuration decoder for the WS2812 channel bank: opcode, channel, value frames.
// Optional mid-frame stall timeout is built only when WS2812_CFG_TIMEOUT_EN is defined.
module ws2812_cfg_decoder #(
  parameter int NUM_CH         = 4,
  parameter int VAL_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int VAL_W         = 8 * VAL_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    f_empty,
  input  logic [7:0]              fifo_read_data,
  output logic                    fifo_read_en,
  output logic [NUM_CH*VAL_W-1:0] data_length,
  output logic [NUM_CH*VAL_W-1:0] data_shift,
  output logic [NUM_CH*VAL_W-1:0] data_delay,
  output logic [NUM_CH*VAL_W-1:0] num_leds,
  output logic [NUM_CH*VAL_W-1:0] data_depth,
  output logic [NUM_CH-1:0]       write,
  output logic                    cfg_err,
  output logic                    busy
);

  // state   | meaning
  // S_REQ     | request a byte when the FIFO is not empty
  // S_WAIT    | read latency cycle
  // S_CAPTURE | store byte into opcode / channel / value field
  // S_COMMIT  | load assembled value into addressed register
  // S_DEPTH   | recompute depth, pulse write
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_CAPTURE, S_COMMIT, S_DEPTH} state_t;

  localparam int         CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [2:0] LAST = 3'(VAL_BYTES + 1);

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic [2:0]       op;
  logic [7:0]       ch;
  logic [VAL_W-1:0] val;
  logic [CH_W-1:0]  ch_idx;
  logic             op_ok, ch_ok, timeout_hit;
  logic [VAL_W+7:0] val_sh;
  logic [VAL_W-1:0] cur_shift, cur_leds, depth_new;

  assign ch_idx = ch[CH_W-1:0];
  assign op_ok  = (fifo_read_data >= 8'h01) && (fifo_read_data <= 8'h04);
  assign ch_ok  = (ch < 8'(NUM_CH));
  assign val_sh = {val, fifo_read_data};

  assign fifo_read_en = !reset && (state == S_REQ) && !f_empty;

`ifdef WS2812_CFG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stall;
  logic            stalling;

  assign stalling    = busy && (state == S_REQ) && f_empty;
  assign timeout_hit = stalling && (stall == '0);

  // Down-counter reloaded on every read; terminal count at zero drops the frame.
  always_ff @(posedge clk) begin
    if (reset || fifo_read_en || timeout_hit) stall <= TO_W'(TIMEOUT_CYCLES - 1);
    else if (stalling)                        stall <= stall - 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:     if (!timeout_hit && !f_empty) state_nxt = S_WAIT;
      S_WAIT:    state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        state_nxt = S_REQ;
        if (cnt == LAST && ch_ok) state_nxt = S_COMMIT;
      end
      S_COMMIT:  state_nxt = S_DEPTH;
      S_DEPTH:   state_nxt = S_REQ;
      default:   state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    cur_shift = data_shift[ch_idx*VAL_W +: VAL_W];
    cur_leds  = num_leds[ch_idx*VAL_W +: VAL_W];
    case (cur_shift)
      VAL_W'(1): depth_new = (cur_leds == '0) ? '0 : cur_leds - 1'b1;
      VAL_W'(2): depth_new = (cur_leds == '1) ? cur_leds : cur_leds + 1'b1;
      default:   depth_new = cur_leds;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      op          <= '0;
      ch          <= '0;
      val         <= '0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      write       <= '0;
      data_length <= '0;
      data_shift  <= '0;
      data_delay  <= '0;
      num_leds    <= '0;
      data_depth  <= '0;
    end else begin
      write   <= '0;
      cfg_err <= 1'b0;
      case (state)
        S_REQ: begin
          if (timeout_hit) begin
            cnt     <= '0;
            busy    <= 1'b0;
            cfg_err <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (cnt == 3'd0) begin
            if (op_ok) begin
              op   <= fifo_read_data[2:0];
              busy <= 1'b1;
              cnt  <= 3'd1;
            end else begin
              cfg_err <= 1'b1;
            end
          end else if (cnt == 3'd1) begin
            ch  <= fifo_read_data;
            cnt <= 3'd2;
          end else begin
            val <= val_sh[VAL_W-1:0];
            if (cnt == LAST) begin
              cnt <= '0;
              // Out-of-range channel: frame fully consumed, then dropped.
              if (!ch_ok) begin
                cfg_err <= 1'b1;
                busy    <= 1'b0;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        S_COMMIT: begin
          busy <= 1'b0;
          case (op)
            3'd1:    data_length[ch_idx*VAL_W +: VAL_W] <= val;
            3'd2:    data_shift[ch_idx*VAL_W +: VAL_W]  <= val;
            3'd3:    data_delay[ch_idx*VAL_W +: VAL_W]  <= val;
            default: num_leds[ch_idx*VAL_W +: VAL_W]    <= val;
          endcase
        end
        S_DEPTH: begin
          write[ch_idx] <= 1'b1;
          if (op == 3'd2 || op == 3'd4) data_depth[ch_idx*VAL_W +: VAL_W] <= depth_new;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_cfg_decoder.sv
// Scoreboard bench for ws2812_cfg_decoder: directed frames queue expected events,
// a monitor checks every write / cfg_err pulse against them.
module tb_ws2812_cfg_decoder;
  localparam int NUM_CH = 4;
  localparam int VAL_BYTES = 2;
  localparam int VAL_W = 16;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_empty;
  logic [7:0]  fifo_read_data = 8'h00;
  logic        fifo_read_en;
  logic [63:0] data_length, data_shift, data_delay, num_leds, data_depth;
  logic [3:0]  write;
  logic        cfg_err, busy;

  ws2812_cfg_decoder #(.NUM_CH(NUM_CH), .VAL_BYTES(VAL_BYTES), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .f_empty(f_empty), .fifo_read_data(fifo_read_data),
    .fifo_read_en(fifo_read_en), .data_length(data_length), .data_shift(data_shift),
    .data_delay(data_delay), .num_leds(num_leds), .data_depth(data_depth),
    .write(write), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [3:0]  wr;
    logic [63:0] len, sh, dl, nl, dp;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int first_rd = -1;

  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign f_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (fifo_read_en) begin
      fifo_read_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
      if (first_rd < 0) first_rd <= cycle;
    end
  end

  logic [15:0] m_len [4];
  logic [15:0] m_sh  [4];
  logic [15:0] m_dl  [4];
  logic [15:0] m_nl  [4];
  logic [15:0] m_dp  [4];

  function automatic logic [63:0] pack4(input logic [15:0] a [4]);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = a[i];
    return r;
  endfunction

  function automatic logic [15:0] ref_depth(input logic [15:0] s, input logic [15:0] n);
    if (s == 16'd1) return (n == 16'h0000) ? 16'h0000 : n - 16'd1;
    if (s == 16'd2) return (n == 16'hFFFF) ? 16'hFFFF : n + 16'd1;
    return n;
  endfunction

  task automatic push_exp(input logic err, input logic [3:0] wr);
    exp_t e;
    e.err = err; e.wr = wr;
    e.len = pack4(m_len); e.sh = pack4(m_sh); e.dl = pack4(m_dl);
    e.nl = pack4(m_nl); e.dp = pack4(m_dp);
    exp_q.push_back(e);
  endtask

  task automatic put(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] ch, input logic [15:0] v);
    put(op); put(ch); put(v[15:8]); put(v[7:0]);
    if (ch >= 8'd4) begin
      push_exp(1'b1, 4'b0000);
    end else begin
      case (op)
        8'h01: m_len[ch[1:0]] = v;
        8'h02: m_sh[ch[1:0]]  = v;
        8'h03: m_dl[ch[1:0]]  = v;
        default: m_nl[ch[1:0]] = v;
      endcase
      if (op == 8'h02 || op == 8'h04)
        m_dp[ch[1:0]] = ref_depth(m_sh[ch[1:0]], m_nl[ch[1:0]]);
      push_exp(1'b0, 4'b0001 << ch[1:0]);
    end
  endtask

  task automatic bad_byte(input logic [7:0] b);
    put(b);
    push_exp(1'b1, 4'b0000);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || rd_ptr != wr_ptr) begin
      errors++;
      $display("FAIL %s drain: pending events %0d, unread bytes %0d, required 0 and 0",
               name, exp_q.size(), wr_ptr - rd_ptr);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && fifo_read_en) begin
      checks++;
      if (f_empty) begin
        errors++;
        $display("FAIL read_while_empty: fifo_read_en=1 f_empty=1, required no read");
      end
    end
    if (!reset && (write != 4'b0000 || cfg_err)) begin
      exp_t e;
      checks++;
      if (write != 4'b0000 && cfg_err) begin
        errors++;
        $display("FAIL write_and_err: write=%b cfg_err=1 in same cycle", write);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: write=%b cfg_err=%b, none expected", write, cfg_err);
      end else begin
        e = exp_q.pop_front();
        if (write !== e.wr || cfg_err !== e.err) begin
          errors++;
          $display("FAIL event: write=%b cfg_err=%b, required write=%b cfg_err=%b",
                   write, cfg_err, e.wr, e.err);
        end
        checks++;
        if (data_length !== e.len || data_shift !== e.sh || data_delay !== e.dl ||
            num_leds !== e.nl || data_depth !== e.dp) begin
          errors++;
          $display("FAIL regs: len=%h sh=%h dl=%h nl=%h dp=%h, required len=%h sh=%h dl=%h nl=%h dp=%h",
                   data_length, data_shift, data_delay, num_leds, data_depth,
                   e.len, e.sh, e.dl, e.nl, e.dp);
        end
      end
    end
  end

  initial begin
    int n;
    int wcyc;
    for (int i = 0; i < 4; i++) begin
      m_len[i] = 0; m_sh[i] = 0; m_dl[i] = 0; m_nl[i] = 0; m_dp[i] = 0;
    end
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    checks++;
    if ({data_length, data_shift, data_delay, num_leds, data_depth} !== 320'd0 ||
        write !== 4'b0 || cfg_err !== 1'b0 || busy !== 1'b0 || fifo_read_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: len=%h nl=%h dp=%h write=%b err=%b busy=%b rd=%b, required all 0",
               data_length, num_leds, data_depth, write, cfg_err, busy, fifo_read_en);
    end

    // First frame with latency measurement from the first read.
    frame(8'h04, 8'h00, 16'h000A);
    n = 0;
    while (write == 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    wcyc = cycle;
    checks++;
    if (write == 4'b0000 || (wcyc - first_rd) != 14) begin
      errors++;
      $display("FAIL latency: write seen=%b after %0d cycles, required 14", write != 0, wcyc - first_rd);
    end
    drain("first_frame", 200);

    frame(8'h04, 8'h02, 16'h0005);
    frame(8'h02, 8'h02, 16'h0001);
    frame(8'h02, 8'h02, 16'h0002);
    drain("shift_modes", 300);

    frame(8'h02, 8'h03, 16'h0001);
    frame(8'h04, 8'h03, 16'h0000);
    frame(8'h02, 8'h03, 16'h0002);
    frame(8'h04, 8'h03, 16'hFFFF);
    frame(8'h02, 8'h00, 16'h0003);
    drain("saturation", 400);

    bad_byte(8'h07);
    frame(8'h03, 8'h01, 16'h1234);
    drain("bad_opcode", 300);

    frame(8'h01, 8'h05, 16'h0010);
    frame(8'h01, 8'h01, 16'h0010);
    drain("bad_channel", 300);

    // Partial frame, then the FIFO runs dry.
    put(8'h01); put(8'h00); put(8'h00);
`ifdef WS2812_CFG_TIMEOUT_EN
    push_exp(1'b1, 4'b0000);
    repeat (2000) @(negedge clk);
    drain("timeout", 100);
    frame(8'h01, 8'h00, 16'h0055);
    drain("after_timeout", 300);
`else
    repeat (2000) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_busy: busy=%b, required 1", busy);
    end
    put(8'h20);
    m_len[0] = 16'h0020;
    push_exp(1'b0, 4'b0001);
    drain("late_byte", 200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
